// File: rtl/ecc_op_scheduler.sv
// rtl/ecc_op_scheduler.sv - sequences GFAU steps for point DOUBLE/ADD/SCALE commands
//
// Ports:
//   clk, reset             single clock; asynchronous active-high reset
//   start, cmd, rep        command request (sampled only in IDLE), opcode, SCALE count
//   x_in, y_in             Montgomery-domain operands latched with start
//   busy, done, error      status; done is a one-cycle pulse, error valid with done
//   x_out, y_out           result registers, held until the next successful done
//   gf_px, gf_py, gf_op    operands and operation select presented to the GFAU
//   gf_start               one-cycle GFAU issue pulse
//   gf_done, gf_px_res,    GFAU completion and results (looked at only in WAIT)
//   gf_py_res
module ecc_op_scheduler #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        cmd,
    input  logic [3:0]        rep,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out,
    output logic [DATA_W-1:0] gf_px,
    output logic [DATA_W-1:0] gf_py,
    output logic [1:0]        gf_op,
    output logic              gf_start,
    input  logic              gf_done,
    input  logic [DATA_W-1:0] gf_px_res,
    input  logic [DATA_W-1:0] gf_py_res
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CMD_DOUBLE = 2'd0;
    localparam logic [1:0] CMD_ADD    = 2'd1;
    localparam logic [1:0] CMD_SCALE  = 2'd2;
    localparam logic [1:0] CMD_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] xr, yr;
    logic [1:0]        cmd_r;
    logic [3:0]        rep_r;
    logic [3:0]        step;
    logic [CNT_W-1:0]  cnt;
    logic              err_r;

    logic              last_step;
    logic [1:0]        seq_op;
    logic              timeout_hit;
    logic              scale_empty;

    // The working registers are what the GFAU sees.
    assign gf_px = xr;
    assign gf_py = yr;

    // A SCALE with zero repetitions has nothing to issue and completes at once.
    assign scale_empty = (cmd == CMD_SCALE) && (rep == 4'd0);

    // Counter value on the TIMEOUT-th WAIT cycle; reaching it without gf_done aborts.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        last_step = 1'b0;
        seq_op    = 2'd0;
        case (cmd_r)
            CMD_DOUBLE: begin
                last_step = (step == 4'd2);
                case (step)
                    4'd0:    seq_op = 2'd3;
                    4'd1:    seq_op = 2'd2;
                    default: seq_op = 2'd0;
                endcase
            end
            CMD_ADD: begin
                last_step = (step == 4'd3);
                case (step)
                    4'd0:       seq_op = 2'd0;
                    4'd1, 4'd2: seq_op = 2'd2;
                    default:    seq_op = 2'd1;
                endcase
            end
            default: begin
                // rep_r is nonzero whenever a SCALE reaches ISSUE/WAIT.
                last_step = (step == (rep_r - 4'd1));
                seq_op    = 2'd2;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_FINISH);
        error     = (state == S_FINISH) && err_r;
        gf_start  = (state == S_ISSUE);
        gf_op     = 2'd0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cmd == CMD_RSVD || scale_empty) state_nxt = S_FINISH;
                    else                                state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gf_op     = seq_op;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                gf_op = seq_op;
                // gf_done takes priority over a coincident timeout.
                if (gf_done)          state_nxt = last_step ? S_FINISH : S_ISSUE;
                else if (timeout_hit) state_nxt = S_FINISH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            xr    <= '0;
            yr    <= '0;
            cmd_r <= 2'd0;
            rep_r <= 4'd0;
            step  <= 4'd0;
            cnt   <= '0;
            err_r <= 1'b0;
            x_out <= '0;
            y_out <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        xr    <= x_in;
                        yr    <= y_in;
                        cmd_r <= cmd;
                        rep_r <= rep;
                        step  <= 4'd0;
                        err_r <= (cmd == CMD_RSVD);
                        // Results must be valid in the same cycle as done.
                        if (scale_empty) begin
                            x_out <= x_in;
                            y_out <= y_in;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt <= '0;
                end
                S_WAIT: begin
                    if (gf_done) begin
                        xr <= gf_px_res;
                        yr <= gf_py_res;
                        if (last_step) begin
                            x_out <= gf_px_res;
                            y_out <= gf_py_res;
                        end else begin
                            step <= step + 4'd1;
                        end
                    end else if (timeout_hit) begin
                        err_r <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_op_scheduler.sv
// tb/tb_ecc_op_scheduler.sv - self-checking bench for ecc_op_scheduler
module tb_ecc_op_scheduler;

    localparam int DW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    cmd;
    logic [3:0]    rep;
    logic [DW-1:0] x_in, y_in;
    logic          busy, done, error;
    logic [DW-1:0] x_out, y_out, gf_px, gf_py;
    logic [1:0]    gf_op;
    logic          gf_start;
    logic          gf_done;
    logic [DW-1:0] gf_px_res, gf_py_res;

    ecc_op_scheduler #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cmd       (cmd),
        .rep       (rep),
        .x_in      (x_in),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .x_out     (x_out),
        .y_out     (y_out),
        .gf_px     (gf_px),
        .gf_py     (gf_py),
        .gf_op     (gf_op),
        .gf_start  (gf_start),
        .gf_done   (gf_done),
        .gf_px_res (gf_px_res),
        .gf_py_res (gf_py_res)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // GFAU stand-in: two-cycle latency, returns (px+1, py+2).
    bit            gfau_en = 1'b1;
    bit            stray   = 1'b0;
    logic          stage, gf_done_m;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stage     <= 1'b0;
            gf_done_m <= 1'b0;
            gf_px_res <= '0;
            gf_py_res <= '0;
        end else begin
            gf_done_m <= stage && gfau_en;
            stage     <= gf_start;
            if (gf_start) begin
                gf_px_res <= gf_px + 32'd1;
                gf_py_res <= gf_py + 32'd2;
            end
        end
    end
    assign gf_done = gf_done_m | stray;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Command-level model: what the outputs must look like, cycle by cycle.
    bit            m_active = 1'b0;
    int            m_t0, m_nsteps, m_done_cyc;
    int            m_ops [16];
    bit            m_err;
    logic [DW-1:0] m_x0, m_y0, m_xo, m_yo;
    logic [DW-1:0] cur_xo = '0, cur_yo = '0;

    task automatic model_launch(input logic [1:0] c, input logic [3:0] r,
                                input logic [DW-1:0] x, input logic [DW-1:0] y);
        int n;
        n = 0;
        case (c)
            2'd0: begin n = 3; m_ops[0] = 3; m_ops[1] = 2; m_ops[2] = 0; end
            2'd1: begin n = 4; m_ops[0] = 0; m_ops[1] = 2; m_ops[2] = 2; m_ops[3] = 1; end
            2'd2: begin n = int'(r); for (int i = 0; i < 16; i++) m_ops[i] = 2; end
            default: n = 0;
        endcase
        m_x0 = x;
        m_y0 = y;
        m_t0 = cyc;
        m_err = (c == 2'd3);
        if (!gfau_en && n > 0) begin
            m_err      = 1'b1;
            m_nsteps   = 1;
            m_done_cyc = m_t0 + 1 + TO + 1;
        end else begin
            m_nsteps   = n;
            m_done_cyc = m_t0 + 3 * n + 1;
        end
        m_xo = x + DW'(n);
        m_yo = y + DW'(2 * n);
        m_active = 1'b1;
    endtask

    task automatic compare();
        bit exp_busy, exp_done, exp_gs;
        int rel, k;
        if (reset) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_error", error, 0);
            chk("rst_gf_start", gf_start, 0);
            chk("rst_gf_op", gf_op, 0);
            chk("rst_x_out", x_out, 0);
            chk("rst_gf_px", gf_px, 0);
            return;
        end
        exp_busy = m_active && cyc > m_t0 && cyc <= m_done_cyc;
        exp_done = m_active && cyc == m_done_cyc;
        exp_gs = 1'b0;
        k = 0;
        if (m_active && cyc > m_t0 && cyc < m_done_cyc) begin
            rel = cyc - m_t0 - 1;
            if (rel % 3 == 0 && rel / 3 < m_nsteps) begin
                exp_gs = 1'b1;
                k = rel / 3;
            end
        end
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("gf_start", gf_start, exp_gs);
        if (exp_gs) begin
            chk("gf_op", gf_op, m_ops[k]);
            chk("gf_px", gf_px, m_x0 + DW'(k));
            chk("gf_py", gf_py, m_y0 + DW'(2 * k));
        end
        if (exp_done) begin
            chk("error", error, m_err);
            if (!m_err) begin
                cur_xo = m_xo;
                cur_yo = m_yo;
            end
            m_active = 1'b0;
        end
        chk("x_out", x_out, cur_xo);
        chk("y_out", y_out, cur_yo);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            compare();
        end
    end

    task automatic launch(input logic [1:0] c, input logic [3:0] r,
                          input logic [DW-1:0] x, input logic [DW-1:0] y);
        @(negedge clk);
        cmd = c; rep = r; x_in = x; y_in = y; start = 1'b1;
        model_launch(c, r, x, y);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic poke_start(input logic [1:0] c);
        @(negedge clk);
        cmd = c; rep = 4'd7; x_in = 32'hDEAD; y_in = 32'hBEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (dc < 0) chk("done_timeout", 0, 1);
    endtask

    int dc, t0;

    initial begin
        reset = 1'b1; start = 1'b0; cmd = 2'd0; rep = 4'd0; x_in = '0; y_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // DOUBLE with two ignored start pulses while busy
        launch(2'd0, 4'd0, 32'h10, 32'h20); t0 = m_t0;
        poke_start(2'd1);
        poke_start(2'd3);
        wait_done(dc);
        chk("double_lat", dc - t0, 10);
        chk("double_err", error, 0);
        chk("double_x", x_out, 32'h13);
        chk("double_y", y_out, 32'h26);
        @(negedge clk);

        launch(2'd1, 4'd0, 32'h0, 32'h0); t0 = m_t0;
        wait_done(dc);
        chk("add_lat", dc - t0, 13);
        chk("add_x", x_out, 32'h4);
        chk("add_y", y_out, 32'h8);
        @(negedge clk);

        launch(2'd2, 4'd0, 32'hAA, 32'h55); t0 = m_t0;
        wait_done(dc);
        chk("scale0_lat", dc - t0, 1);
        chk("scale0_x", x_out, 32'hAA);
        chk("scale0_y", y_out, 32'h55);
        @(negedge clk);

        launch(2'd2, 4'd15, 32'h100, 32'h200); t0 = m_t0;
        wait_done(dc);
        chk("scale15_lat", dc - t0, 46);
        chk("scale15_x", x_out, 32'h10F);
        chk("scale15_y", y_out, 32'h21E);
        @(negedge clk);

        launch(2'd3, 4'd0, 32'h1, 32'h2); t0 = m_t0;
        wait_done(dc);
        chk("rsvd_lat", dc - t0, 1);
        chk("rsvd_err", error, 1);
        chk("rsvd_x_held", x_out, 32'h10F);
        @(negedge clk);

        // GFAU never answers: abort TIMEOUT+1 cycles after gf_start
        gfau_en = 1'b0;
        launch(2'd0, 4'd0, 32'h5, 32'h6); t0 = m_t0;
        wait_done(dc);
        chk("timeout_lat", dc - (t0 + 1), TO + 1);
        chk("timeout_err", error, 1);
        chk("timeout_x_held", x_out, 32'h10F);
        @(negedge clk);
        gfau_en = 1'b1;

        // stray gf_done while IDLE
        stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_x_held", x_out, 32'h10F);

        // reset in the middle of WAIT
        launch(2'd1, 4'd0, 32'h1, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        m_active = 1'b0;
        cur_xo = '0;
        cur_yo = '0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        launch(2'd0, 4'd0, 32'h10, 32'h20); t0 = m_t0;
        wait_done(dc);
        chk("post_rst_lat", dc - t0, 10);
        chk("post_rst_x", x_out, 32'h13);
        chk("post_rst_y", y_out, 32'h26);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
